bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: cascaded-decade BCD up/down timer with a start/stop/hold
// control FSM.
//
// Optional build macro: BCD_TIMER_RELOAD_EN. When it is defined, a run that
// reaches its terminal count reloads on the next edge and keeps running
// (periodic mode), and done never asserts. In the default build (macro
// undefined) a run stops in DONE at its terminal count.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   start   - begin a run from IDLE/DONE, resume from HOLD
//   stop    - pause a run, or abort from HOLD to IDLE; wins over start
//   dwn_up  - direction, 0 = up, 1 = down; sampled only in LOAD
//   preset  - packed BCD target, digit 0 in bits [3:0]
//   count   - packed BCD current count
//   busy    - high in LOAD, RUN and HOLD
//   done    - high only in DONE
//   tc      - one-cycle pulse per terminal-count event
//   err     - sticky flag, a preset digit above 9 was clamped to 9
module bcd_timer_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dwn_up,
    input  logic [4*DIGITS-1:0] preset,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                done,
    output logic                tc,
    output logic                err
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t         state;
    logic           dir;
    logic [W-1:0]   limit;

    logic [W-1:0]   clamped;
    logic           preset_bad;
    logic [W-1:0]   load_val;
    logic           load_term;
    logic [W-1:0]   stepped;
    logic           stepped_term;
    logic [3:0]     digit;
    logic           carry;

    // Preset digits above 9 are clamped to 9 and flagged.
    always_comb begin
        clamped    = '0;
        preset_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (preset[4*i +: 4] > 4'd9) begin
                clamped[4*i +: 4] = 4'd9;
                preset_bad        = 1'b1;
            end else begin
                clamped[4*i +: 4] = preset[4*i +: 4];
            end
        end
    end

    // Load value depends on the direction being latched in the same cycle.
    // Both directions are already terminal when the limit is zero.
    always_comb begin
        load_val  = dwn_up ? clamped : '0;
        load_term = (clamped == '0);
    end

    // One BCD step: a digit moves only while every lower digit wraps.
    always_comb begin
        stepped = count;
        carry   = 1'b1;
        digit   = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                if (dir) begin
                    if (digit == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digit - 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (digit >= 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        stepped_term = dir ? (stepped == '0) : (stepped == limit);
    end

`ifdef BCD_TIMER_RELOAD_EN
    logic           run_at_term;
    logic [W-1:0]   reload_val;

    // Periodic mode: a count sitting at terminal is replaced by the reload value.
    always_comb begin
        run_at_term = dir ? (count == '0) : (count == limit);
        reload_val  = dir ? limit : '0;
    end
`endif

    // Control FSM with registered outputs; busy/done track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            tc    <= 1'b0;
            err   <= 1'b0;
            dir   <= 1'b0;
            limit <= '0;
        end else begin
            tc <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start && !stop) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                S_LOAD: begin
                    dir   <= dwn_up;
                    limit <= clamped;
                    err   <= preset_bad;
                    count <= load_val;
                    if (load_term) begin
`ifdef BCD_TIMER_RELOAD_EN
                        state <= S_RUN;
                        tc    <= 1'b1;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        tc    <= 1'b1;
`endif
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state <= S_HOLD;
                    end else begin
`ifdef BCD_TIMER_RELOAD_EN
                        if (run_at_term) begin
                            count <= reload_val;
                            tc    <= (limit == '0);
                        end else begin
                            count <= stepped;
                            tc    <= stepped_term;
                        end
`else
                        count <= stepped;
                        if (stepped_term) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            tc    <= 1'b1;
                        end
`endif
                    end
                end

                S_HOLD: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl: directed scenarios plus a randomized run,
// all checked against an integer-valued behavioural model of the timer.
module tb_bcd_timer_ctrl;

    localparam int unsigned DIG = 4;
    localparam int unsigned W   = 4 * DIG;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HOLD = 3;
    localparam int M_DONE = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           dwn_up;
    logic [W-1:0]   preset;
    logic [W-1:0]   count;
    logic           busy;
    logic           done;
    logic           tc;
    logic           err;

    int tests = 0;
    int fails = 0;

    // Model state: plain integers for count/limit.
    int m_mode  = M_IDLE;
    int m_count = 0;
    int m_limit = 0;
    bit m_dir   = 1'b0;
    bit m_err   = 1'b0;
    bit m_tc    = 1'b0;

    bcd_timer_ctrl #(.DIGITS(DIG)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .dwn_up (dwn_up),
        .preset (preset),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .tc     (tc),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIG); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit at_terminal();
        return m_dir ? (m_count == 0) : (m_count == m_limit);
    endfunction

    function automatic logic [W+3:0] expv();
        return {to_bcd(m_count),
                (m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_HOLD),
                (m_mode == M_DONE), m_tc, m_err};
    endfunction

    task automatic model_edge(input logic r, input logic st, input logic sp,
                              input logic du, input logic [W-1:0] pr);
        int lim;
        int scale;
        int d;
        bit bad;
        m_tc = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_count = 0; m_limit = 0; m_dir = 1'b0; m_err = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: if (!sp && st) m_mode = M_LOAD;
            M_LOAD: begin
                lim = 0; scale = 1; bad = 1'b0;
                for (int i = 0; i < int'(DIG); i++) begin
                    d = int'(pr[4*i +: 4]);
                    if (d > 9) begin d = 9; bad = 1'b1; end
                    lim += d * scale;
                    scale *= 10;
                end
                m_dir = du; m_limit = lim; m_err = bad;
                m_count = du ? lim : 0;
                if (lim == 0) begin
`ifdef BCD_TIMER_RELOAD_EN
                    m_mode = M_RUN;
`else
                    m_mode = M_DONE;
`endif
                    m_tc = 1'b1;
                end else begin
                    m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (sp) m_mode = M_HOLD;
                else begin
`ifdef BCD_TIMER_RELOAD_EN
                    if (at_terminal()) begin
                        m_count = m_dir ? m_limit : 0;
                        m_tc = (m_limit == 0);
                    end else begin
                        m_count += m_dir ? -1 : 1;
                        m_tc = at_terminal();
                    end
`else
                    m_count += m_dir ? -1 : 1;
                    if (at_terminal()) begin m_mode = M_DONE; m_tc = 1'b1; end
`endif
                end
            end
            M_HOLD: begin
                if (sp) begin m_mode = M_IDLE; m_count = 0; end
                else if (st) m_mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, advance DUT and model, sample 1 ns later.
    task automatic cycle(input logic r, input logic st, input logic sp,
                         input logic du, input logic [W-1:0] pr);
        rst = r; start = st; stop = sp; dwn_up = du; preset = pr;
        @(posedge clk);
        model_edge(r, st, sp, du, pr);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tests++;
        if ({count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL reset_model: got %h expected %h", {count, busy, done, tc, err}, expv());
        end
        tests++;
        if ({count, busy, done, tc, err} !== 20'h00000) begin
            fails++;
            $display("FAIL reset_zero: got %h expected 00000", {count, busy, done, tc, err});
        end
        // start and stop together in IDLE: stop wins, nothing happens
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
        tests++;
        if (busy !== 1'b0 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL idle_stop_priority: got %h expected %h", {count, busy, done, tc, err}, expv());
        end
    endtask

`ifndef BCD_TIMER_RELOAD_EN
    task automatic test_down_basic();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0003);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        tests++;
        if (count !== 16'h0003 || busy !== 1'b1 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL down_load: got count=%h busy=%b expected count=0003 busy=1", count, busy);
        end
        // preset/direction changes during the run must be ignored
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h9999);
            tests++;
            if ({count, busy, done, tc, err} !== expv()) begin
                fails++;
                $display("FAIL down_step%0d: got %h expected %h", i, {count, busy, done, tc, err}, expv());
            end
        end
        tests++;
        if (count !== 16'h0000 || done !== 1'b1 || tc !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL down_terminal: got count=%h done=%b tc=%b busy=%b expected 0000 1 1 0",
                     count, done, tc, busy);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (count !== 16'h0000 || done !== 1'b1 || tc !== 1'b0) begin
            fails++;
            $display("FAIL down_tc_width: got count=%h done=%b tc=%b expected 0000 1 0", count, done, tc);
        end
    endtask

    task automatic test_up_bcd();
        int steps;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0120);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0120);
        tests++;
        if ({count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL up_load: got %h expected %h", {count, busy, done, tc, err}, expv());
        end
        steps = 0;
        while (done !== 1'b1 && steps < 200) begin
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom), W'($urandom));
            steps++;
            tests++;
            if ({count, busy, done, tc, err} !== expv()) begin
                fails++;
                $display("FAIL up_step%0d: got %h expected %h", steps, {count, busy, done, tc, err}, expv());
            end
        end
        tests++;
        if (steps != 120 || count !== 16'h0120 || done !== 1'b1) begin
            fails++;
            $display("FAIL up_length: got steps=%0d count=%h expected steps=120 count=0120", steps, count);
        end
    endtask

    task automatic test_clamp();
        int n;
        logic [W-1:0] frozen;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h00A5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5);
        tests++;
        if (err !== 1'b1 || count !== 16'h0000) begin
            fails++;
            $display("FAIL clamp_err: got err=%b count=%h expected err=1 count=0000", err, count);
        end
        n = 0;
        while (done !== 1'b1 && n < 150) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            n++;
        end
        tests++;
        if (count !== 16'h0095 || n != 95 || err !== 1'b1 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL clamp_limit: got count=%h steps=%0d err=%b expected 0095 95 1", count, n, err);
        end
        // zero preset down: LOAD goes straight to DONE, err clears
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || count !== 16'h0000 || err !== 1'b0) begin
            fails++;
            $display("FAIL zero_preset: got done=%b busy=%b count=%h err=%b expected 1 0 0000 0",
                     done, busy, count, err);
        end
        // start and stop together in RUN -> HOLD with count frozen
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050);
        frozen = count;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0050);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050);
        tests++;
        if (count !== 16'h0048 || frozen !== 16'h0048 || busy !== 1'b1 ||
            {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL start_stop_run: got count=%h busy=%b expected 0048 1", count, busy);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask
`else
    task automatic test_reload();
        int pulses;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0002);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0002);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            if (tc === 1'b1) pulses++;
            tests++;
            if (done !== 1'b0 || {count, busy, done, tc, err} !== expv()) begin
                fails++;
                $display("FAIL reload_cycle%0d: got %h expected %h", i, {count, busy, done, tc, err}, expv());
            end
        end
        tests++;
        if (pulses != 3) begin
            fails++;
            $display("FAIL reload_pulses: got %0d expected 3", pulses);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask
`endif

    task automatic test_hold();
        int n;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        n = 0;
        while (count !== 16'h0997 && n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            n++;
        end
        tests++;
        if (count !== 16'h0997) begin
            fails++;
            $display("FAIL hold_reach: got count=%h expected 0997 within 20 cycles", count);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom), W'($urandom));
            tests++;
            if (count !== 16'h0997 || busy !== 1'b1 || {count, busy, done, tc, err} !== expv()) begin
                fails++;
                $display("FAIL hold_frozen%0d: got count=%h busy=%b expected 0997 1", i, count, busy);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (count !== 16'h0996 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL hold_resume: got count=%h expected 0996", count);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tests++;
        if (count !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL hold_abort: got count=%h busy=%b done=%b expected 0000 0 0", count, busy, done);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0999);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0999);
        n = 0;
        while (count !== 16'h0456 && n < 600) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0999);
            n++;
        end
        tests++;
        if (count !== 16'h0456 || n != 456) begin
            fails++;
            $display("FAIL rst_reach: got count=%h after %0d steps expected 0456 after 456", count, n);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
        tests++;
        if ({count, busy, done, tc, err} !== 20'h00000 || {count, busy, done, tc, err} !== expv()) begin
            fails++;
            $display("FAIL rst_mid_run: got %h expected 00000", {count, busy, done, tc, err});
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tests++;
        if (busy !== 1'b0 || count !== 16'h0000) begin
            fails++;
            $display("FAIL rst_stays_idle: got busy=%b count=%h expected 0 0000", busy, count);
        end
    endtask

    task automatic test_random();
        logic r, st, sp, du;
        logic [31:0] v;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 11) == 0);
            du = 1'($urandom);
            v  = $urandom;
            if ($urandom_range(0, 3) != 0) v = v & 32'h0000_00FF;
            cycle(r, st, sp, du, W'(v));
            tests++;
            if ({count, busy, done, tc, err} !== expv()) begin
                fails++;
                $display("FAIL random%0d: got %h expected %h", i, {count, busy, done, tc, err}, expv());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwn_up = 1'b0; preset = '0;
        test_reset();
`ifndef BCD_TIMER_RELOAD_EN
        test_down_basic();
        test_up_bcd();
        test_clamp();
`else
        test_reload();
`endif
        test_hold();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
